demux_1to4_stream: RTL and testbench
====================================

Name: demux_1to4_stream

Overview:
Registered 1-to-4 stream demultiplexer. It routes each input word to one of four output channels selected by a 2-bit select. The block uses a valid/ready handshake on every side and a single holding register.
It is the distribution counterpart of the team's 4:1 selection muxes. It sits wherever one producer must feed one of four consumers.
Throughput is one word per clock when the addressed consumer is ready.

Parameters:
DATA_W, 8, width of the data word

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
sel  input  2  destination channel for the current input word, sampled with in_data
in_valid  input  1  input word valid
in_data  input  DATA_W  input word
in_ready  output  1  block can accept a word this cycle
out_valid  output  4  one-hot valid, bit k = word present for channel k
out_data  output  DATA_W  shared output data bus, meaningful only on the channel with out_valid set
out_ready  input  4  per-channel consumer ready

Behaviour:
- State: one holding register made of data_q, sel_q and full_q. Two states:
  - EMPTY (full_q=0)
  - FULL (full_q=1)
- Reset, synchronous, active-high:
  - full_q=0, sel_q=0, data_q=0
  - out_valid=4'b0000, out_data=0
  - in_ready=1 from the first cycle after rst deasserts
  - Reset mid-operation discards any held word without delivering it.
- Outputs:
  - out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000. Registered state only, so out_valid has no combinational path from in_valid or sel.
  - out_data = data_q.
  - drain = full_q & out_ready[sel_q]. Ready bits of non-selected channels are ignored.
  - in_ready = ~full_q | drain. This is combinational from out_ready; the block is intentionally a pass-through-ready slice.
  - accept = in_valid & in_ready.
- Transitions:
  - EMPTY, accept: load data_q←in_data, sel_q←sel, go FULL.
  - EMPTY, no accept: hold.
  - FULL, drain & accept: load the new word, stay FULL. This is back-to-back, zero-bubble operation.
  - FULL, drain & ~accept: go EMPTY. data_q and sel_q hold their values; out_valid goes to 0.
  - FULL, ~drain: hold data_q and sel_q stable. in_ready=0.
- Latency: a word accepted in cycle N is presented on out_valid/out_data in cycle N+1.
- Ordering: strict FIFO order across all channels. A stalled destination blocks every following word, including words for other channels (head-of-line blocking by design).
- in_data and sel are ignored when in_valid=0. No word is ever duplicated, dropped or delivered to a non-selected channel.
- At most one out_valid bit is set in any cycle.

Optional Feature:
Macro DEMUX_CNT_EN.
- Defined:
  - Adds output port cnt (4*16 bits). cnt[16k+15:16k] counts completed handshakes on channel k, i.e. cycles with out_valid[k] & out_ready[k].
  - Each counter resets to 0 on rst and wraps 16'hFFFF→16'h0000 without saturation.
  - A drain and a new accept in the same cycle count exactly one transfer.
- Not defined: the cnt port and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with in_valid=1, in_data=8'hAA. Required while rst=1 and in the first cycle after release: out_valid=0000, out_data=00. in_ready=1 from the first cycle after release.
2. Single route: out_ready=1111; send 8'h11 to sel=2 in cycle N. Required in cycle N+1: out_valid=0100, out_data=11. Required in cycle N+2: out_valid=0000.
3. Back-to-back: out_ready=1111; stream 8'h01,02,03,04 with sel=0,1,2,3 on consecutive cycles. Required on 4 consecutive cycles: out_valid=0001,0010,0100,1000 with matching data, no bubble, in_ready=1 throughout.
4. Stall/HOL: send 8'h5A to sel=1 with out_ready=1101, then hold in_valid=1, data 8'hC3, sel=0. Required:
   - out_valid=0010 and out_data=5A stable
   - in_ready=0 while out_ready[1]=0
   - after out_ready[1]=1 for one cycle: next cycle out_valid=0001, out_data=C3.
5. Reset mid-stall: reproduce scenario 4 stall, assert rst one cycle. Required: the word is discarded, out_valid=0000, in_ready=1 next cycle, and 8'h5A is never delivered.
6. With DEMUX_CNT_EN:
   - 3 transfers to ch3 and 1 to ch0 → cnt ch3=3, ch0=1, others 0.
   - Preload 65535 transfers on ch1, then one more → ch1 counter=0.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - registered 1:4 stream demux, optional per-channel counters under DEMUX_CNT_EN
module demux_1to4_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [63:0]       cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        valid_q;
    logic              drain;
    logic              accept;

    // Ready passes straight through from the addressed consumer so a draining slot refills without a bubble.
    assign drain     = (state_q == FULL) & out_ready[sel_q];
    assign in_ready  = (state_q == EMPTY) | drain;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sel_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 4'b0000;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        data_q  <= in_data;
                        sel_q   <= sel;
                        valid_q <= 4'b0001 << sel;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (drain) begin
                        if (accept) begin
                            data_q  <= in_data;
                            sel_q   <= sel;
                            valid_q <= 4'b0001 << sel;
                        end else begin
                            valid_q <= 4'b0000;
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_q [4];

    // Counters wrap naturally; a refill in the draining cycle is still one transfer.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                cnt_q[k] <= 16'd0;
            end else if (valid_q[k] & out_ready[k]) begin
                cnt_q[k] <= cnt_q[k] + 16'd1;
            end
        end
    end

    assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - bench for demux_1to4_stream against a queue-based reference
module tb_demux_1to4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
`ifdef DEMUX_CNT_EN
    logic [63:0] cnt;
`endif

    always #5 clk = ~clk;

    demux_1to4_stream #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } word_t;

    word_t       pend[$];
    logic [7:0]  last_data;
    int          exp_cnt [4];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the reference, then advance the reference across the edge.
    task automatic cycle();
        logic [3:0] e_valid;
        logic       e_ready;
        logic       dr;
        #3;
        e_valid = (pend.size() != 0) ? (4'b0001 << pend[0].ch) : 4'b0000;
        e_ready = (pend.size() == 0) || out_ready[pend[0].ch];
        chk("out_valid", {60'd0, out_valid}, {60'd0, e_valid});
        chk("out_data", {56'd0, out_data}, {56'd0, last_data});
        if (!rst) chk("in_ready", {63'd0, in_ready}, {63'd0, e_ready});
`ifdef DEMUX_CNT_EN
        for (int k = 0; k < 4; k++)
            chk("cnt", {48'd0, cnt[16*k +: 16]}, 64'(exp_cnt[k]));
`endif
        if (rst) begin
            pend.delete();
            last_data = 8'h00;
            for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        end else begin
            dr = (pend.size() != 0) && out_ready[pend[0].ch];
            if (dr) begin
                exp_cnt[pend[0].ch] = (exp_cnt[pend[0].ch] + 1) % 65536;
                void'(pend.pop_front());
            end
            if (in_valid && e_ready) begin
                pend.push_back('{ch: sel, data: in_data});
                last_data = in_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 2'd3, 8'hAA, 4'b1111);
        last_data = 8'h00;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        @(posedge clk);
        #1;
        // reset held with traffic present
        repeat (3) cycle();
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();

        // single route
        drive(1'b1, 2'd2, 8'h11, 4'b1111);
        cycle();
        drive(1'b0, 2'd0, 8'hFF, 4'b1111);
        cycle();
        cycle();

        // back-to-back over all channels
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(i + 1), 4'b1111);
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();
        cycle();

        // stall and head-of-line blocking
        drive(1'b1, 2'd1, 8'h5A, 4'b1101);
        cycle();
        drive(1'b1, 2'd0, 8'hC3, 4'b1101);
        repeat (3) cycle();
        out_ready = 4'b1111;
        cycle();
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();
        cycle();

        // reset during a stall discards the held word
        drive(1'b1, 2'd1, 8'h5A, 4'b1101);
        cycle();
        drive(1'b1, 2'd0, 8'hC3, 4'b1101);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        repeat (3) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
            cycle();
        end

`ifdef DEMUX_CNT_EN
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 8'(8'h30 + i), 4'b1111);
            cycle();
        end
        drive(1'b1, 2'd0, 8'h40, 4'b1111);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();
        chk("cnt_ch3", {48'd0, cnt[63:48]}, 64'd3);
        chk("cnt_ch0", {48'd0, cnt[15:0]}, 64'd1);
        chk("cnt_ch12", {32'd0, cnt[47:16]}, 64'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b1, 2'd1, 8'h77, 4'b1111);
        for (int i = 0; i < 65536; i++) cycle();
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle();
        chk("cnt_ch1_wrap", {48'd0, cnt[31:16]}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
